pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the five-stage AArch64 pipeline. It drives the `en`/`clr` pair of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It sequences four hazard types: load-use, EX-stage redirect, multi-cycle MUL/DIV occupancy of EX, and memory-port wait, with full flush on exception. It sits beside the datapath and contains the only pipeline-wide state machine.

## Interface
Parameters:
- `MUL_LAT`, 3: cycles a MUL occupies EX (≥1).
- `DIV_LAT`, 16: cycles a DIV occupies EX (≥1).

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-low.
- `id_ra`, `id_rb` in 5 each: source register indices in ID.
- `id_ra_vld`, `id_rb_vld` in 1 each: the matching source is actually read.
- `ex_dst` in 5: destination register of the instruction in EX.
- `ex_wen` in 1: the EX instruction writes `ex_dst`.
- `ex_is_load` in 1: the EX instruction is a load.
- `ex_mdu_start` in 1: a MUL/DIV instruction is valid in EX this cycle.
- `ex_mdu_is_div` in 1: selects `DIV_LAT` when set, otherwise `MUL_LAT`.
- `ex_redirect` in 1: EX resolved a taken or mispredicted branch.
- `imem_busy` in 1: instruction fetch is outstanding.
- `dmem_busy` in 1: data access in MEM is outstanding.
- `flush_all` in 1: exception or trap committed from WB.
- `pc_en` out 1: PC register enable.
- `ifid_en`, `ifid_clr` out 1 each: IF/ID register controls.
- `idex_en`, `idex_clr` out 1 each: ID/EX register controls.
- `exmem_en`, `exmem_clr` out 1 each: EX/MEM register controls.
- `memwb_en`, `memwb_clr` out 1 each: MEM/WB register controls.
- `redir_pending` out 1: fetch must keep selecting the latched redirect target.
- `mdu_busy` out 1: EX is held by MUL/DIV.

## Operation
Register semantics:
- `en=1, clr=1` loads a bubble (all zeros).
- `en=1, clr=0` advances.
- `en=0` holds.

States: `RUN`, `MDU_WAIT`, `REDIR_HOLD`. The 5-bit down-counter `cnt` tracks MDU occupancy.

Load-use hazard condition: `ex_is_load & ex_wen & ex_dst!=31` and the destination matches a valid `id_ra` or `id_rb`.

Outputs are combinational from state and inputs. Priority, highest first:
1. `flush_all`: `pc_en=1`; all four registers `en=1, clr=1`. Next state is `RUN`, `cnt=0`, pending redirect dropped. This overrides `dmem_busy`; the memory side aborts the access itself.
2. `dmem_busy`:
   - `pc`, IF/ID, ID/EX and EX/MEM get `en=0`.
   - MEM/WB gets `en=1, clr=1`.
   - State holds.
   - `cnt` still decrements, saturating at 0.
   - A redirect arriving now is not taken, because EX is frozen and re-presents it.
3. `MDU_WAIT`:
   - While `cnt≠0`: `pc`, IF/ID and ID/EX `en=0`; EX/MEM `en=1, clr=1`; MEM/WB advances; `cnt--`.
   - When `cnt==0`: everything advances and the state goes to `RUN`.
4. `REDIR_HOLD`:
   - While `imem_busy`: `pc_en=0`; IF/ID and ID/EX `en=1, clr=1`; EX/MEM and MEM/WB advance.
   - When `!imem_busy`: `pc_en=1`; IF/ID `clr=1`; state goes to `RUN`.
   - `redir_pending=1` throughout this state.
5. `RUN` with `ex_mdu_start` and latency >1: load `cnt = LAT-2`, go to `MDU_WAIT`, and apply the stall outputs of item 3 this cycle. With latency 1, no stall.
6. `RUN` with `ex_redirect`:
   - If `imem_busy`: go to `REDIR_HOLD` with the same outputs as that state.
   - Otherwise: `pc_en=1`; IF/ID and ID/EX `en=1, clr=1`.
   - Redirect overrides load-use, because the ID instruction is on the wrong path.
7. `RUN` with load-use: `pc_en=0`, `ifid_en=0`; ID/EX `en=1, clr=1`; others advance.
8. `RUN` with `imem_busy` only: `pc_en=0`; IF/ID `en=1, clr=1`; others advance.
9. Otherwise all enables are 1 and all clears are 0.

Other outputs: `mdu_busy` is 1 exactly in cycles where item 3 or 5 stalls.

## Timing
- In reset, the state is `RUN` and `cnt=0`.
- While `rst` is low, every `en`, `clr`, `redir_pending` and `mdu_busy` output is 0, so the pipeline freezes.
- Reset asserted mid-`MDU_WAIT` or mid-`REDIR_HOLD` returns to `RUN` immediately, asynchronously.
- A MUL/DIV instruction stays in EX for exactly LAT cycles, then advances on the edge after the LAT-th cycle. This assumes no `dmem_busy` in between; any `dmem_busy` cycles extend the time only if the count has already reached 0.
- Load-use costs 1 bubble.
- A redirect costs 2 bubbles plus the number of `imem_busy` cycles.
- `flush_all` takes effect on the same edge.

## Structure
- Package `pipes` holds `ctrl_state_t` (enum: `RUN`, `MDU_WAIT`, `REDIR_HOLD`) and `preg_ctrl_t` (struct `{en, clr}`). The output bundle is `preg_ctrl_t` for each of the four registers.
- One natural sub-module: `hazard_detect`, combinational, producing the load-use condition.

## Test plan
- Idle `RUN`: all `en=1`, all `clr=0`, `pc_en=1`.
- Load `ex_dst=5`, `ex_wen=1`, with `id_ra=5`, `id_ra_vld=1`:
  - One cycle of `pc_en=0`, `ifid_en=0`, `idex_clr=1`.
  - With `ex_dst=31` instead: no stall.
- DIV start with `DIV_LAT=16`: `mdu_busy` stays high for 15 cycles, `exmem_clr=1` in each; release on cycle 16.
- `ex_redirect` with `imem_busy` high for 3 cycles:
  - `redir_pending` high 3 cycles, `pc_en=0`.
  - Then a single `pc_en=1` with `ifid_clr=1`, and state returns to `RUN`.
- `dmem_busy` for 4 cycles during a MUL wait: front end frozen; `memwb_clr=1` for 4 cycles; `cnt` still reaches 0.
- `flush_all` during `MDU_WAIT` with `dmem_busy=1`:
  - Same cycle: all four `clr=1`, `pc_en=1`.
  - Next cycle: state is `RUN`.
- Async `rst` pulse mid-`REDIR_HOLD`: all outputs go to 0 at once; after release the block is in `RUN` with `redir_pending=0`.

Source files
------------

// File: rtl/pipes.sv
// Shared types for the pipeline stall/flush controller.
package pipes;

    typedef enum logic [1:0] {
        RUN,
        MDU_WAIT,
        REDIR_HOLD
    } ctrl_state_t;

    typedef struct packed {
        logic en;
        logic clr;
    } preg_ctrl_t;

    localparam preg_ctrl_t P_ADV  = '{en: 1'b1, clr: 1'b0};
    localparam preg_ctrl_t P_HOLD = '{en: 1'b0, clr: 1'b0};
    localparam preg_ctrl_t P_BUB  = '{en: 1'b1, clr: 1'b1};
    localparam preg_ctrl_t P_OFF  = '{en: 1'b0, clr: 1'b0};

    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detection between the ID sources and a load in EX.
module hazard_detect
    import pipes::*;
(
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_ra_vld,
    input  logic       id_rb_vld,
    input  logic [4:0] ex_dst,
    input  logic       ex_wen,
    input  logic       ex_is_load,
    output logic       load_use
);

    logic ld_live;
    logic hit_a;
    logic hit_b;

    // Register 31 is the zero register and never carries a dependency.
    assign ld_live  = ex_is_load & ex_wen & (ex_dst != XZR);
    assign hit_a    = id_ra_vld & (id_ra == ex_dst);
    assign hit_b    = id_rb_vld & (id_rb == ex_dst);
    assign load_use = ld_live & (hit_a | hit_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-wide stall/flush sequencer: drives en/clr of every
// pipeline register and the PC enable.
module pipe_hazard_ctrl
    import pipes::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_ra_vld,
    input  logic       id_rb_vld,
    input  logic [4:0] ex_dst,
    input  logic       ex_wen,
    input  logic       ex_is_load,
    input  logic       ex_mdu_start,
    input  logic       ex_mdu_is_div,
    input  logic       ex_redirect,
    input  logic       imem_busy,
    input  logic       dmem_busy,
    input  logic       flush_all,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_clr,
    output logic       idex_en,
    output logic       idex_clr,
    output logic       exmem_en,
    output logic       exmem_clr,
    output logic       memwb_en,
    output logic       memwb_clr,
    output logic       redir_pending,
    output logic       mdu_busy
);

    ctrl_state_t state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        load_use;
    logic        pc_c;
    logic        rp_c;
    logic        mb_c;
    preg_ctrl_t  ifid_c, idex_c, exmem_c, memwb_c;
    int unsigned lat;

    hazard_detect u_hd (
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_ra_vld  (id_ra_vld),
        .id_rb_vld  (id_rb_vld),
        .ex_dst     (ex_dst),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .load_use   (load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_c    = 1'b1;
        ifid_c  = P_ADV;
        idex_c  = P_ADV;
        exmem_c = P_ADV;
        memwb_c = P_ADV;
        rp_c    = 1'b0;
        mb_c    = 1'b0;
        lat     = ex_mdu_is_div ? DIV_LAT : MUL_LAT;

        if (flush_all) begin
            ifid_c  = P_BUB;
            idex_c  = P_BUB;
            exmem_c = P_BUB;
            memwb_c = P_BUB;
            state_d = RUN;
            cnt_d   = '0;
        end else if (dmem_busy) begin
            // EX is frozen, so any redirect or MDU start re-presents later.
            pc_c    = 1'b0;
            ifid_c  = P_HOLD;
            idex_c  = P_HOLD;
            exmem_c = P_HOLD;
            memwb_c = P_BUB;
            rp_c    = (state_q == REDIR_HOLD);
            cnt_d   = (cnt_q != '0) ? cnt_q - 5'd1 : '0;
        end else if (state_q == MDU_WAIT) begin
            if (cnt_q != '0) begin
                pc_c    = 1'b0;
                ifid_c  = P_HOLD;
                idex_c  = P_HOLD;
                exmem_c = P_BUB;
                mb_c    = 1'b1;
                cnt_d   = cnt_q - 5'd1;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == REDIR_HOLD) begin
            rp_c   = 1'b1;
            ifid_c = P_BUB;
            if (imem_busy) begin
                pc_c   = 1'b0;
                idex_c = P_BUB;
            end else begin
                state_d = RUN;
            end
        end else if (ex_mdu_start && lat > 1) begin
            // The start cycle counts as the first EX cycle.
            pc_c    = 1'b0;
            ifid_c  = P_HOLD;
            idex_c  = P_HOLD;
            exmem_c = P_BUB;
            mb_c    = 1'b1;
            cnt_d   = 5'(lat - 2);
            state_d = MDU_WAIT;
        end else if (ex_redirect) begin
            ifid_c = P_BUB;
            idex_c = P_BUB;
            if (imem_busy) begin
                pc_c    = 1'b0;
                rp_c    = 1'b1;
                state_d = REDIR_HOLD;
            end
        end else if (load_use) begin
            pc_c   = 1'b0;
            ifid_c = P_HOLD;
            idex_c = P_BUB;
        end else if (imem_busy) begin
            pc_c   = 1'b0;
            ifid_c = P_BUB;
        end

        if (!rst) begin
            pc_c    = 1'b0;
            ifid_c  = P_OFF;
            idex_c  = P_OFF;
            exmem_c = P_OFF;
            memwb_c = P_OFF;
            rp_c    = 1'b0;
            mb_c    = 1'b0;
        end
    end

    assign pc_en         = pc_c;
    assign ifid_en       = ifid_c.en;
    assign ifid_clr      = ifid_c.clr;
    assign idex_en       = idex_c.en;
    assign idex_clr      = idex_c.clr;
    assign exmem_en      = exmem_c.en;
    assign exmem_clr     = exmem_c.clr;
    assign memwb_en      = memwb_c.en;
    assign memwb_clr     = memwb_c.clr;
    assign redir_pending = rp_c;
    assign mdu_busy      = mb_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed output vectors.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_ra = '0, id_rb = '0, ex_dst = '0;
    logic       id_ra_vld = 0, id_rb_vld = 0, ex_wen = 0, ex_is_load = 0;
    logic       ex_mdu_start = 0, ex_mdu_is_div = 0, ex_redirect = 0;
    logic       imem_busy = 0, dmem_busy = 0, flush_all = 0;
    logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic       exmem_en, exmem_clr, memwb_en, memwb_clr;
    logic       redir_pending, mdu_busy;

    int tests = 0;
    int fails = 0;

    // {pc, ifid en/clr, idex en/clr, exmem en/clr, memwb en/clr, rp, mb}
    localparam logic [10:0] ZERO  = 11'b0_00_00_00_00_0_0;
    localparam logic [10:0] IDLE  = 11'b1_10_10_10_10_0_0;
    localparam logic [10:0] LU    = 11'b0_00_11_10_10_0_0;
    localparam logic [10:0] MDU   = 11'b0_00_00_11_10_0_1;
    localparam logic [10:0] RHB   = 11'b0_11_11_10_10_1_0;
    localparam logic [10:0] RHR   = 11'b1_11_10_10_10_1_0;
    localparam logic [10:0] RDIR  = 11'b1_11_11_10_10_0_0;
    localparam logic [10:0] IMEM  = 11'b0_11_10_10_10_0_0;
    localparam logic [10:0] DMEM  = 11'b0_00_00_00_11_0_0;
    localparam logic [10:0] FLUSH = 11'b1_11_11_11_11_0_0;

    wire [10:0] obs = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                       exmem_en, exmem_clr, memwb_en, memwb_clr,
                       redir_pending, mdu_busy};

    pipe_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_ra         (id_ra),
        .id_rb         (id_rb),
        .id_ra_vld     (id_ra_vld),
        .id_rb_vld     (id_rb_vld),
        .ex_dst        (ex_dst),
        .ex_wen        (ex_wen),
        .ex_is_load    (ex_is_load),
        .ex_mdu_start  (ex_mdu_start),
        .ex_mdu_is_div (ex_mdu_is_div),
        .ex_redirect   (ex_redirect),
        .imem_busy     (imem_busy),
        .dmem_busy     (dmem_busy),
        .flush_all     (flush_all),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_clr      (ifid_clr),
        .idex_en       (idex_en),
        .idex_clr      (idex_clr),
        .exmem_en      (exmem_en),
        .exmem_clr     (exmem_clr),
        .memwb_en      (memwb_en),
        .memwb_clr     (memwb_clr),
        .redir_pending (redir_pending),
        .mdu_busy      (mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check at the falling edge, then move inputs just after the rising edge.
    task automatic cyc(input string tag, input logic [10:0] exp);
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("reset_zero", ZERO);
        #10 rst = 1'b1;
        @(posedge clk); #1;
        cyc("idle0", IDLE);
        cyc("idle1", IDLE);

        ex_is_load = 1; ex_wen = 1; ex_dst = 5; id_ra = 5; id_ra_vld = 1;
        cyc("lu_ra", LU);
        ex_is_load = 0;
        cyc("lu_after", IDLE);
        ex_is_load = 1; ex_dst = 31; id_ra = 31;
        cyc("lu_xzr", IDLE);
        ex_dst = 7; id_rb = 7; id_rb_vld = 1; id_ra = 2;
        cyc("lu_rb", LU);
        id_rb_vld = 0;
        cyc("lu_rb_novld", IDLE);
        ex_is_load = 0; ex_wen = 0; id_ra_vld = 0;

        ex_mdu_start = 1; ex_mdu_is_div = 1;
        cyc("div_start", MDU);
        ex_mdu_start = 0;
        for (int i = 0; i < 14; i++) cyc("div_wait", MDU);
        cyc("div_release", IDLE);
        cyc("div_run", IDLE);

        ex_mdu_start = 1; ex_mdu_is_div = 0;
        cyc("mul_start", MDU);
        ex_mdu_start = 0; dmem_busy = 1;
        for (int i = 0; i < 4; i++) cyc("mul_dmem", DMEM);
        dmem_busy = 0;
        cyc("mul_release", IDLE);
        cyc("mul_run", IDLE);

        ex_redirect = 1; imem_busy = 1;
        cyc("redir_busy0", RHB);
        ex_redirect = 0;
        cyc("redir_busy1", RHB);
        cyc("redir_busy2", RHB);
        imem_busy = 0;
        cyc("redir_release", RHR);
        cyc("redir_run", IDLE);

        ex_redirect = 1;
        cyc("redir_nobusy", RDIR);
        ex_is_load = 1; ex_wen = 1; ex_dst = 5; id_ra = 5; id_ra_vld = 1;
        cyc("redir_over_lu", RDIR);
        ex_redirect = 0; ex_is_load = 0; ex_wen = 0; id_ra_vld = 0;
        imem_busy = 1;
        cyc("imem_only", IMEM);

        ex_redirect = 1; dmem_busy = 1;
        cyc("dmem_redir", DMEM);
        ex_redirect = 0; imem_busy = 0; dmem_busy = 0;
        cyc("dmem_redir_after", IDLE);

        ex_mdu_start = 1; ex_mdu_is_div = 1;
        cyc("fl_div_start", MDU);
        ex_mdu_start = 0;
        cyc("fl_div_wait", MDU);
        flush_all = 1; dmem_busy = 1;
        cyc("flush", FLUSH);
        flush_all = 0; dmem_busy = 0;
        cyc("flush_after", IDLE);
        cyc("flush_run", IDLE);

        ex_redirect = 1; imem_busy = 1;
        cyc("rst_redir0", RHB);
        ex_redirect = 0;
        #1 rst = 1'b0;
        #1 chk("rst_async", ZERO);
        #1 rst = 1'b1;
        cyc("rst_release", IMEM);
        imem_busy = 0;
        cyc("rst_run", IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
